// File: rtl/step_counter_pkg.sv
// step_counter_pkg: shared types and helpers for the step_counter block.
//   dir_t        - counting direction (DIR_DOWN = 0, DIR_UP = 1)
//   presc_width  - prescaler register width for a given DIV, minimum 1 bit
package step_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/step_counter_tick_divider.sv
// tick_divider: clock-enable prescaler for step_counter.
// Counts 0..DIV-1 on enabled cycles and asserts fire on the enabled cycle
// that completes a period. With DIV=1 the count stays 0 and fire = enable.
// Ports:
//   clock   in  sole clock, posedge
//   reset_  in  synchronous active-high reset, count -> 0
//   enable  in  advance the count; hold when low
//   clear   in  restart the period (count -> 0)
//   fire    out high on the enabled cycle that completes a period
module tick_divider
  import step_counter_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset_,
  input  logic enable,
  input  logic clear,
  output logic fire
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Priority against load is resolved by the owner of the counter.
  assign fire = enable && (presc_q == LAST);

endmodule

// File: rtl/step_counter.sv
// step_counter: paced up/down counter with prescaler, parallel load and
// overflow/underflow pulse.
// Optional feature macro: STEP_COUNTER_SATURATE_EN (clamp at the bounds
// instead of wrapping). Default build wraps modulo 2^WIDTH.
// Parameters: WIDTH (counter width), STEP (increment), DIV (prescaler ratio).
// Ports:
//   clock       in   sole clock, posedge
//   reset_      in   synchronous active-high reset
//   enable      in   advance the prescaler
//   up          in   1 = add STEP, 0 = subtract STEP
//   load        in   parallel load request (beats a coincident update)
//   load_value  in   value captured on load
//   value       out  registered counter value
//   tick        out  registered pulse marking a counter update
//   limit       out  registered pulse: update carried or borrowed
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int DIV   = 2
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             tick,
  output logic             limit
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

  logic             fire;
  dir_t             dir;
  logic [WIDTH:0]   res;
  logic [WIDTH-1:0] value_q, value_d;
  logic             tick_q, tick_d;
  logic             limit_q, limit_d;

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clock  (clock),
    .reset_ (reset_),
    .enable (enable),
    .clear  (load),
    .fire   (fire)
  );

`ifdef STEP_COUNTER_SATURATE_EN
  // Out-of-range result pins to the bound it tried to cross.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] raw,
                                                input dir_t d);
    if (raw[WIDTH]) begin
      return (d == DIR_UP) ? '1 : '0;
    end
    return raw[WIDTH-1:0];
  endfunction
`endif

  assign dir = dir_t'(up);

  // Extra top bit carries the carry (up) or borrow (down).
  assign res = (dir == DIR_UP) ? ({1'b0, value_q} + STEP_W)
                               : ({1'b0, value_q} - STEP_W);

  always_comb begin
    value_d = value_q;
    tick_d  = 1'b0;
    limit_d = 1'b0;
    if (load) begin
      value_d = load_value;
    end else if (fire) begin
`ifdef STEP_COUNTER_SATURATE_EN
      value_d = saturate(res, dir);
`else
      value_d = res[WIDTH-1:0];
`endif
      tick_d  = 1'b1;
      limit_d = res[WIDTH];
    end
  end

  // Output register stage
  always_ff @(posedge clock) begin
    if (reset_) begin
      value_q <= '0;
      tick_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      value_q <= value_d;
      tick_q  <= tick_d;
      limit_q <= limit_d;
    end
  end

  assign value = value_q;
  assign tick  = tick_q;
  assign limit = limit_q;

endmodule

// File: tb/tb_step_counter.sv
module tb_step_counter;

`ifdef STEP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // A: DIV=2 STEP=1   B: DIV=1 STEP=1   C: DIV=1 STEP=4   D: DIV=4 STEP=1
  logic        en_a, up_a, ld_a, tk_a, lm_a;
  logic        en_b, up_b, ld_b, tk_b, lm_b;
  logic        en_c, up_c, ld_c, tk_c, lm_c;
  logic        en_d, up_d, ld_d, tk_d, lm_d;
  logic [15:0] lv_a, lv_b, lv_c, lv_d;
  logic [15:0] va_a, va_b, va_c, va_d;

  step_counter #(.WIDTH(16), .STEP(1), .DIV(2)) dut_a (
    .clock(clk), .reset_(rst), .enable(en_a), .up(up_a), .load(ld_a),
    .load_value(lv_a), .value(va_a), .tick(tk_a), .limit(lm_a));
  step_counter #(.WIDTH(16), .STEP(1), .DIV(1)) dut_b (
    .clock(clk), .reset_(rst), .enable(en_b), .up(up_b), .load(ld_b),
    .load_value(lv_b), .value(va_b), .tick(tk_b), .limit(lm_b));
  step_counter #(.WIDTH(16), .STEP(4), .DIV(1)) dut_c (
    .clock(clk), .reset_(rst), .enable(en_c), .up(up_c), .load(ld_c),
    .load_value(lv_c), .value(va_c), .tick(tk_c), .limit(lm_c));
  step_counter #(.WIDTH(16), .STEP(1), .DIV(4)) dut_d (
    .clock(clk), .reset_(rst), .enable(en_d), .up(up_d), .load(ld_d),
    .load_value(lv_d), .value(va_d), .tick(tk_d), .limit(lm_d));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic [15:0] v, input logic t, input logic l);
    chk({tag, ".value"}, {16'h0, va_d}, {16'h0, v});
    chk({tag, ".tick"},  {31'h0, tk_d}, {31'h0, t});
    chk({tag, ".limit"}, {31'h0, lm_d}, {31'h0, l});
  endtask

  initial begin
    rst = 1'b1;
    {en_a, up_a, ld_a, en_b, up_b, ld_b} = '0;
    {en_c, up_c, ld_c, en_d, up_d, ld_d} = '0;
    {lv_a, lv_b, lv_c, lv_d} = '0;
    step();
    step();
    chk("rst.a.value", {16'h0, va_a}, 32'h0);
    chk("rst.a.tick",  {31'h0, tk_a}, 32'h0);
    chk("rst.a.limit", {31'h0, lm_a}, 32'h0);
    chk("rst.b.value", {16'h0, va_b}, 32'h0);
    chk("rst.d.value", {16'h0, va_d}, 32'h0);

    // A: count up at half rate for 10 cycles
    rst  = 1'b0;
    en_a = 1'b1;
    up_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("a.c%0d.value", k), {16'h0, va_a}, 32'(k / 2));
      chk($sformatf("a.c%0d.tick", k),  {31'h0, tk_a}, 32'((k % 2) == 0));
      chk($sformatf("a.c%0d.limit", k), {31'h0, lm_a}, 32'h0);
    end
    en_a = 1'b0;

    // B: overflow at the top bound
    ld_b = 1'b1; lv_b = 16'hFFFE; up_b = 1'b1; en_b = 1'b1;
    step();
    chk("b.load.value", {16'h0, va_b}, 32'hFFFE);
    chk("b.load.tick",  {31'h0, tk_b}, 32'h0);
    ld_b = 1'b0;
    step();
    chk("b.top.value", {16'h0, va_b}, 32'hFFFF);
    chk("b.top.tick",  {31'h0, tk_b}, 32'h1);
    chk("b.top.limit", {31'h0, lm_b}, 32'h0);
    step();
    chk("b.ovf.value", {16'h0, va_b}, SAT ? 32'hFFFF : 32'h0000);
    chk("b.ovf.tick",  {31'h0, tk_b}, 32'h1);
    chk("b.ovf.limit", {31'h0, lm_b}, 32'h1);
    step();
    chk("b.post.value", {16'h0, va_b}, SAT ? 32'hFFFF : 32'h0001);
    chk("b.post.limit", {31'h0, lm_b}, SAT ? 32'h1 : 32'h0);
    en_b = 1'b0;
    step();
    chk("b.hold.value", {16'h0, va_b}, SAT ? 32'hFFFF : 32'h0001);
    chk("b.hold.tick",  {31'h0, tk_b}, 32'h0);
    chk("b.hold.limit", {31'h0, lm_b}, 32'h0);

    // C: underflow with STEP=4
    ld_c = 1'b1; lv_c = 16'h0003; up_c = 1'b0; en_c = 1'b1;
    step();
    chk("c.load.value", {16'h0, va_c}, 32'h0003);
    ld_c = 1'b0;
    step();
    chk("c.udf.value", {16'h0, va_c}, SAT ? 32'h0000 : 32'hFFFF);
    chk("c.udf.tick",  {31'h0, tk_c}, 32'h1);
    chk("c.udf.limit", {31'h0, lm_c}, 32'h1);
    en_c = 1'b0;

    // D: enable gap mid-period, DIV=4
    en_d = 1'b1; up_d = 1'b1;
    step(); chk_d("d.e1", 16'h0, 1'b0, 1'b0);
    step(); chk_d("d.e2", 16'h0, 1'b0, 1'b0);
    en_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk_d($sformatf("d.gap%0d", k), 16'h0, 1'b0, 1'b0);
    end
    en_d = 1'b1;
    step(); chk_d("d.e3", 16'h0, 1'b0, 1'b0);
    step(); chk_d("d.e4", 16'h1, 1'b1, 1'b0);

    // D: load coincident with a firing update
    for (int k = 1; k <= 3; k++) begin
      step(); chk_d($sformatf("d.pre%0d", k), 16'h1, 1'b0, 1'b0);
    end
    ld_d = 1'b1; lv_d = 16'h1234;
    step(); chk_d("d.ldfire", 16'h1234, 1'b0, 1'b0);
    ld_d = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(); chk_d($sformatf("d.post%0d", k), 16'h1234, 1'b0, 1'b0);
    end
    step(); chk_d("d.post4", 16'h1235, 1'b1, 1'b0);

    // D: reset mid-period
    ld_d = 1'b1; lv_d = 16'h00A0;
    step(); chk_d("d.ldA0", 16'h00A0, 1'b0, 1'b0);
    ld_d = 1'b0;
    step();
    step(); chk_d("d.mid", 16'h00A0, 1'b0, 1'b0);
    rst = 1'b1;
    step(); chk_d("d.rst", 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(); chk_d($sformatf("d.rel%0d", k), 16'h0, 1'b0, 1'b0);
    end
    step(); chk_d("d.rel4", 16'h1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised up/down counter with programmable prescaler, parallel load and overflow/underflow reporting. Generalises the sandbox mouse counter: arbitrary width and step size, a clock-enable divider in place of the fixed half-rate toggle, and a wrap or saturate mode. Sits between pointer/mouse input decoding and display or control logic that needs a paced, bounded position value.

## Interface
- WIDTH, 16, bit width of counter and load value (≥ 2)
- STEP, 1, magnitude added/subtracted per tick (1 ≤ STEP < 2^WIDTH)
- DIV, 2, prescaler ratio; counter updates once per DIV enabled clocks (≥ 1)

- clock  input  1  sole clock, all state on posedge
- reset_  input  1  synchronous, active-high reset
- enable  input  1  advances prescaler when high; prescaler and counter hold when low
- up  input  1  direction: 1 = add STEP, 0 = subtract STEP
- load  input  1  parallel load request
- load_value  input  WIDTH  value captured on load
- value  output  WIDTH  registered counter value
- tick  output  1  registered one-cycle pulse marking a counter update
- limit  output  1  registered one-cycle pulse: update crossed 0 or 2^WIDTH-1

## Operation
- Priority per cycle: reset_ > load > tick update > hold.
- Reset: value=0, prescaler=0, tick=0, limit=0.
- Load: value←load_value, prescaler←0, tick=0, limit=0 next cycle; up/enable ignored that cycle.
- Prescaler: counts 0..DIV-1 while enable=1; on enable=1 with prescaler=DIV-1 it returns to 0 and an update fires. DIV=1: update on every enabled cycle, prescaler constant 0.
- Update: computed in WIDTH+1 bits. Up: sum=value+STEP; carry set → limit. Down: diff=value−STEP; borrow set → limit.
- Wrap mode (default): value←low WIDTH bits of sum/diff (modulo 2^WIDTH).
- limit and tick are 0 on every non-update cycle.
- up may change every cycle; only its value on the update cycle matters.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Load latency 1: load high in cycle N → value=load_value in N+1.
- Update latency 1: enabling cycle N completes prescaler period → value, tick, limit change in N+1 together.
- From reset release with enable held high: first tick at cycle DIV after release, then every DIV cycles.
- enable low mid-period: prescaler frozen, resumes from same count; no lost or extra ticks.
- load coincident with a firing update: load wins, update discarded, no tick/limit.
- reset_ mid-period: state to reset values next cycle; period restarts.

## Configuration
- STEP_COUNTER_SATURATE_EN defined: on carry value←2^WIDTH-1, on borrow value←0; limit still pulses on the clamping update and on each further update attempting to pass the bound.
- Undefined: wrap mode as above; no clamping logic synthesised.

## Structure
- Package step_counter_pkg: dir_t enum (DIR_DOWN=0, DIR_UP=1); localparam function for prescaler width, $clog2(DIV) with minimum 1.
- One sub-module tick_divider (DIV parameter; clock, reset_, enable, clear in; fire out) holding the prescaler; step_counter owns value, arithmetic, mode logic and output registers.

## Test plan
- Reset then WIDTH=16, DIV=2, STEP=1, enable=1, up=1 for 10 cycles → value 0,0,1,1,…; tick on alternate cycles, value=5 at cycle 10, limit never set.
- Load 16'hFFFE, up=1, DIV=1, STEP=1 → 16'hFFFF (limit=0), then 16'h0000 with limit=1; with STEP_COUNTER_SATURATE_EN value stays 16'hFFFF, limit=1 on each further tick.
- Load 16'h0003, up=0, STEP=4, DIV=1 → next value 16'hFFFF with limit=1 (wrap) or 16'h0000 with limit=1 (saturate).
- DIV=4, enable dropped for 3 cycles after 2 enabled cycles → tick appears only after 4 total enabled cycles; value increments once.
- load asserted in the same cycle the prescaler fires, load_value=16'h1234 → value=16'h1234, tick=0, limit=0; next tick DIV enabled cycles later.
- reset_ pulsed for one cycle mid-period with value=16'h00A0 → value=0, tick=0, limit=0 next cycle; first tick DIV cycles after release.
